// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port: FSM state constants,
// index widths and the byte-enable decoder used by the store path.
package dmem_pkg;

    localparam int WORD_IDX_W = 6;
    localparam int LANE_W     = 2;

    localparam logic [0:0] INIT  = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [LANE_W-1:0] lane;
    } lane_sel_t;

    // Turns a one-hot byte enable into a lane number; zero or multi-hot
    // patterns come back with valid cleared so the store can be rejected.
    function automatic lane_sel_t onehot4_to_lane(input logic [3:0] be);
        lane_sel_t sel;
        sel.valid = 1'b1;
        sel.lane  = '0;
        case (be)
            4'b0001: sel.lane = 2'd0;
            4'b0010: sel.lane = 2'd1;
            4'b0100: sel.lane = 2'd2;
            4'b1000: sel.lane = 2'd3;
            default: sel.valid = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised local RAM with asynchronous read and per-byte write
// enables. Contents are never reset; the port's clear sequencer fills it.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int WORDS = 64
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [WORD_IDX_W-1:0] waddr_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    input  logic [WORD_IDX_W-1:0] raddr_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [WORDS];

    // Byte-lane write: only lanes with their enable set are overwritten.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int l = 0; l < 4; l++) begin
                if (be_i[l]) begin
                    mem_q[waddr_i][8*l +: 8] <= wdata_i[8*l +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_port.sv
// Data-memory stage: post-reset clear sequencer, byte-lane store path,
// one memory-mapped output word and a reject flag for illegal stores.
// Optional store counter output wr_count is built when DMEM_WRCOUNT_EN
// is defined.
module dmem_port
    import dmem_pkg::*;
#(
    parameter int          WORDS     = 64,
    parameter int          MMIO_WORD = 0,
    parameter logic [31:0] INIT_VAL  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  access_address,
    input  logic [7:0]  data_write,
    input  logic [3:0]  byte_enable,
    input  logic        write_enable,
    output logic [31:0] data_read,
    output logic        mem_busy,
    output logic [31:0] mmio_out,
    output logic        err_pulse
`ifdef DMEM_WRCOUNT_EN
    ,
    output logic [15:0] wr_count
`endif
);

    logic [0:0]            state_q, state_d;
    logic [WORD_IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic [31:0]           mmio_q, mmio_d;
    logic                  err_q, err_d;

    logic [WORD_IDX_W-1:0] word_idx;
    lane_sel_t             sel;
    logic                  is_mmio;
    logic                  store_ok;
    logic                  unused_addr_lsb;

    logic                  ram_we;
    logic [WORD_IDX_W-1:0] ram_waddr;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    assign word_idx        = access_address[7:2];
    assign unused_addr_lsb = ^access_address[1:0];
    assign sel             = onehot4_to_lane(byte_enable);
    assign is_mmio         = (word_idx == WORD_IDX_W'(MMIO_WORD));
    assign store_ok        = write_enable && (state_q == READY) && sel.valid;

    // Next-state logic: the clear sequencer owns the RAM write port in INIT,
    // the core's stores own it in READY; anything else is flagged as an error.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mmio_d    = mmio_q;
        err_d     = write_enable && !store_ok;
        ram_we    = 1'b0;
        ram_waddr = word_idx;
        ram_be    = 4'b0000;
        ram_wdata = {4{data_write}};
        if (state_q == INIT) begin
            ram_waddr = clr_idx_q;
            ram_be    = 4'b1111;
            ram_wdata = INIT_VAL;
            ram_we    = (clr_idx_q != WORD_IDX_W'(MMIO_WORD));
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == WORD_IDX_W'(WORDS - 1)) begin
                state_d = READY;
            end
        end else if (store_ok) begin
            if (is_mmio) begin
                mmio_d[{sel.lane, 3'b000} +: 8] = data_write;
            end else begin
                ram_we = 1'b1;
                ram_be = 4'b0001 << sel.lane;
            end
        end
    end

    // State registers; reset restarts the sequencer and drops the MMIO word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= INIT;
            clr_idx_q <= '0;
            mmio_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            mmio_q    <= mmio_d;
            err_q     <= err_d;
        end
    end

    dmem_ram #(
        .WORDS (WORDS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .raddr_i (word_idx),
        .rdata_o (ram_rdata)
    );

    assign data_read = (state_q == INIT) ? 32'h0 : (is_mmio ? mmio_q : ram_rdata);
    assign mem_busy  = (state_q == INIT);
    assign mmio_out  = mmio_q;
    assign err_pulse = err_q;

`ifdef DMEM_WRCOUNT_EN
    logic [15:0] wr_count_q;

    // Saturating count of accepted stores, RAM and MMIO alike.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_count_q <= '0;
        end else if (store_ok && (wr_count_q != 16'hFFFF)) begin
            wr_count_q <= wr_count_q + 16'd1;
        end
    end

    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: directed scenarios with literal
// expectations plus a randomized phase compared every cycle against a
// behavioural memory model. Define DMEM_WRCOUNT_EN to cover wr_count.
module tb_dmem_port;

    localparam logic [31:0] INIT_VAL = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  access_address = '0;
    logic [7:0]  data_write = '0;
    logic [3:0]  byte_enable = '0;
    logic        write_enable = 1'b0;
    logic [31:0] data_read;
    logic        mem_busy;
    logic [31:0] mmio_out;
    logic        err_pulse;
`ifdef DMEM_WRCOUNT_EN
    logic [15:0] wr_count;
`endif

    int compared = 0;
    int mismatched = 0;
    logic checkEn = 1'b0;

    dmem_port dut (
        .clk            (clk),
        .reset          (reset),
        .access_address (access_address),
        .data_write     (data_write),
        .byte_enable    (byte_enable),
        .write_enable   (write_enable),
        .data_read      (data_read),
        .mem_busy       (mem_busy),
        .mmio_out       (mmio_out),
        .err_pulse      (err_pulse)
`ifdef DMEM_WRCOUNT_EN
        ,
        .wr_count       (wr_count)
`endif
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Behavioural model: memory as an array, busy as a countdown of
    // remaining clear cycles; the clear becomes visible all at once.
    logic [31:0] mRam [64];
    logic [31:0] mMmio = '0;
    logic        mErr = 1'b0;
    logic [15:0] mCount = '0;
    int          initLeft = 64;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            initLeft = 64;
            mMmio    = '0;
            mErr     = 1'b0;
            mCount   = '0;
        end else begin
            mErr = write_enable && (initLeft > 0 || $countones(byte_enable) != 1);
            if (initLeft > 0) begin
                initLeft = initLeft - 1;
                if (initLeft == 0) begin
                    for (int w = 0; w < 64; w++) mRam[w] = INIT_VAL;
                end
            end else if (write_enable && $countones(byte_enable) == 1) begin
                int lane;
                int w;
                lane = 0;
                for (int l = 0; l < 4; l++) if (byte_enable[l]) lane = l;
                w = int'(access_address) / 4;
                if (w == 0) mMmio[lane*8 +: 8] = data_write;
                else        mRam[w][lane*8 +: 8] = data_write;
                if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            logic [31:0] expRead;
            if (initLeft > 0) expRead = 32'h0;
            else if (access_address[7:2] == 6'd0) expRead = mMmio;
            else expRead = mRam[access_address[7:2]];
            checkOutput("model.data_read", data_read, expRead);
            checkOutput("model.mem_busy", 32'(mem_busy), 32'(initLeft > 0));
            checkOutput("model.mmio_out", mmio_out, mMmio);
            checkOutput("model.err_pulse", 32'(err_pulse), 32'(mErr));
`ifdef DMEM_WRCOUNT_EN
            checkOutput("model.wr_count", 32'(wr_count), 32'(mCount));
`endif
        end
    end

    task automatic applyStimulus(input logic [7:0] addr, input logic [3:0] be,
                                 input logic [7:0] data, input logic we);
        @(posedge clk);
        #1;
        access_address = addr;
        byte_enable    = be;
        data_write     = data;
        write_enable   = we;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        write_enable = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic doStore(input logic [7:0] addr, input logic [3:0] be, input logic [7:0] data);
        applyStimulus(addr, be, data, 1'b1);
        applyStimulus(addr, 4'b0000, 8'h00, 1'b0);
    endtask

    task automatic readCheck(input string name, input logic [7:0] addr, input logic [31:0] exp);
        access_address = addr;
        @(negedge clk);
        checkOutput(name, data_read, exp);
    endtask

    task automatic waitReady(output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (!mem_busy) break;
            n++;
        end
    endtask

    initial begin
        int n;
        checkEn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset in the middle of the clear sequence, then a full clear
        repeat (30) applyStimulus(8'h00, 4'b0000, 8'h00, 1'b0);
        pulseReset();
        waitReady(n);
        checkOutput("busyCycles", 32'(n), 32'd64);
        checkOutput("mmioAfterClear", mmio_out, 32'h0);
`ifdef DMEM_WRCOUNT_EN
        checkOutput("wrCountAfterReset", 32'(wr_count), 32'd0);
`endif
        for (int w = 0; w < 64; w++) begin
            applyStimulus(8'(w * 4), 4'b0000, 8'h00, 1'b0);
            @(negedge clk);
            checkOutput("clearRead", data_read, 32'h0);
        end

        // Lane 2 store with a same-cycle read that must still see old data
        applyStimulus(8'h14, 4'b0100, 8'hA5, 1'b1);
        @(negedge clk);
        checkOutput("noBypass", data_read, 32'h0);
        applyStimulus(8'h14, 4'b0000, 8'h00, 1'b0);
        readCheck("store1", 8'h14, 32'h00A5_0000);

        doStore(8'h15, 4'b0001, 8'h3C);
        readCheck("store2", 8'h14, 32'h00A5_003C);

        doStore(8'h02, 4'b1000, 8'h7E);
        checkOutput("mmioStore", mmio_out, 32'h7E00_0000);
        readCheck("mmioRead", 8'h00, 32'h7E00_0000);
        readCheck("ram1Intact", 8'h04, 32'h0);
`ifdef DMEM_WRCOUNT_EN
        checkOutput("wrCountThree", 32'(wr_count), 32'd3);
`endif

        // Multi-hot byte enable is rejected with a single-cycle flag
        applyStimulus(8'h14, 4'b0011, 8'hFF, 1'b1);
        applyStimulus(8'h14, 4'b0000, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("rejectErr", 32'(err_pulse), 32'd1);
        checkOutput("rejectNoWrite", data_read, 32'h00A5_003C);
        applyStimulus(8'h14, 4'b0000, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("rejectErrDrop", 32'(err_pulse), 32'd0);

        // Store during the clear sequence is rejected too
        pulseReset();
        applyStimulus(8'h08, 4'b0001, 8'h55, 1'b1);
        applyStimulus(8'h08, 4'b0000, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("initRejectErr", 32'(err_pulse), 32'd1);
        applyStimulus(8'h08, 4'b0000, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("initRejectDrop", 32'(err_pulse), 32'd0);
        waitReady(n);
        checkOutput("readyAfterInit", 32'(mem_busy), 32'd0);
        readCheck("initRejectNoWrite", 8'h08, 32'h0);
        checkOutput("mmioCleared", mmio_out, 32'h0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            logic [7:0] addr;
            logic [3:0] be;
            if ($urandom_range(0, 399) == 0) begin
                pulseReset();
            end else begin
                addr = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) addr = addr & 8'h1F;
                if ($urandom_range(0, 9) < 7) be = 4'b0001 << $urandom_range(0, 3);
                else be = 4'($urandom_range(0, 15));
                applyStimulus(addr, be, 8'($urandom), 1'($urandom_range(0, 1)));
            end
        end
        applyStimulus(8'h00, 4'b0000, 8'h00, 1'b0);
        @(negedge clk);
        checkEn = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
